regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, mul/div).

---
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ writeback sources,
// with a registered write stage, decode-side bypass and a saturating conflict counter.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [ADDR_W-1:0]         q_addr1,
    input  logic [ADDR_W-1:0]         q_addr2,
    output logic                      fwd_hit1,
    output logic                      fwd_hit2,
    output logic [DATA_W-1:0]         fwd_data,
    output logic [CNT_W-1:0]          conflict_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0] wrData_q, wrData_d;
    logic [CNT_W-1:0]  conflictCnt_q, conflictCnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grantIdx;
    logic               accept;
    logic [ADDR_W-1:0]  selAddr;
    logic [DATA_W-1:0]  selData;
    logic               multiValid;

    // Search starts at ptr and wraps; the extra sum bit keeps ptr+k from overflowing before the wrap.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        grant    = '0;
        grantIdx = '0;
        accept   = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!accept && reset && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grantIdx   = idx;
                accept     = 1'b1;
            end
        end
    end

    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                selAddr = req_addr[i*ADDR_W +: ADDR_W];
                selData = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // The granted source drops to lowest priority on the following cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            if (grantIdx == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grantIdx + 1'b1;
            end
        end
    end

    // Writes to r0 are accepted but never reach the register file.
    always_comb begin
        wrEn_d   = accept && (selAddr != '0);
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        if (wrEn_d) begin
            wrAddr_d = selAddr;
            wrData_d = selData;
        end
    end

    assign multiValid = |(req_valid & (req_valid - 1'b1));

    always_comb begin
        conflictCnt_d = conflictCnt_q;
        if (multiValid && (conflictCnt_q != '1)) begin
            conflictCnt_d = conflictCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q         <= '0;
            wrEn_q        <= 1'b0;
            wrAddr_q      <= '0;
            wrData_q      <= '0;
            conflictCnt_q <= '0;
        end else begin
            ptr_q         <= ptr_d;
            wrEn_q        <= wrEn_d;
            wrAddr_q      <= wrAddr_d;
            wrData_q      <= wrData_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign req_ready    = grant;
    assign rf_we        = wrEn_q;
    assign rf_waddr     = wrAddr_q;
    assign rf_wdata     = wrData_q;
    assign fwd_hit1     = wrEn_q && (wrAddr_q == q_addr1) && (q_addr1 != '0);
    assign fwd_hit2     = wrEn_q && (wrAddr_q == q_addr2) && (q_addr2 != '0);
    assign fwd_data     = wrData_q;
    assign conflict_cnt = conflictCnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a cycle-level reference model checked every negedge,
// plus literal expectations for the key scenarios.
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  reqValid;
    logic [AW-1:0] addrArr [N];
    logic [DW-1:0] dataArr [N];
    logic [N*AW-1:0] reqAddr;
    logic [N*DW-1:0] reqData;
    logic [N-1:0]  reqReady;
    logic          rfWe;
    logic [AW-1:0] rfWaddr;
    logic [DW-1:0] rfWdata;
    logic [AW-1:0] qAddr1, qAddr2;
    logic          fwdHit1, fwdHit2;
    logic [DW-1:0] fwdData;
    logic [CW-1:0] conflictCnt;

    int testsRun    = 0;
    int testsFailed = 0;
    bit compareEn   = 1'b0;

    int            mPtr;
    bit            mWe;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mData;
    int            mCnt;

    always #5 clk = ~clk;

    assign reqAddr = {addrArr[2], addrArr[1], addrArr[0]};
    assign reqData = {dataArr[2], dataArr[1], dataArr[0]};

    regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(reqValid),
        .req_addr(reqAddr),
        .req_data(reqData),
        .req_ready(reqReady),
        .rf_we(rfWe),
        .rf_waddr(rfWaddr),
        .rf_wdata(rfWdata),
        .q_addr1(qAddr1),
        .q_addr2(qAddr2),
        .fwd_hit1(fwdHit1),
        .fwd_hit2(fwdHit2),
        .fwd_data(fwdData),
        .conflict_cnt(conflictCnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int pickSource(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Inputs only change just after posedge, so the values seen here are the ones the next edge samples:
    // compare against the model first, then advance the model across that edge.
    always @(negedge clk) begin
        int            g;
        logic [N-1:0]  expReady;
        g = pickSource(mPtr, reqValid);
        expReady = '0;
        if (reset === 1'b1 && g >= 0) expReady[g] = 1'b1;
        if (compareEn) begin
            checkOutput("cmp_ready", reqReady, expReady);
            checkOutput("cmp_we", rfWe, mWe);
            checkOutput("cmp_waddr", rfWaddr, mAddr);
            checkOutput("cmp_wdata", rfWdata, mData);
            checkOutput("cmp_hit1", fwdHit1, mWe && (mAddr == qAddr1) && (qAddr1 != 0));
            checkOutput("cmp_hit2", fwdHit2, mWe && (mAddr == qAddr2) && (qAddr2 != 0));
            checkOutput("cmp_fwddata", fwdData, mData);
            checkOutput("cmp_cnt", conflictCnt, 64'(mCnt));
        end
        if (reset !== 1'b1) begin
            mPtr = 0; mWe = 0; mAddr = '0; mData = '0; mCnt = 0;
        end else begin
            if ($countones(reqValid) >= 2 && mCnt < 65535) mCnt++;
            mWe = 0;
            if (g >= 0) begin
                mPtr = (g + 1) % N;
                if (addrArr[g] != 0) begin
                    mWe   = 1;
                    mAddr = addrArr[g];
                    mData = dataArr[g];
                end
            end
        end
    end

    initial begin
        logic [N-1:0] expSeq [6];
        expSeq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        reset = 1'b0;
        reqValid = '0;
        qAddr1 = '0;
        qAddr2 = '0;
        for (int i = 0; i < N; i++) begin
            addrArr[i] = '0;
            dataArr[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 compareEn = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", reqReady, 3'b000);
        checkOutput("reset_we", rfWe, 1'b0);
        checkOutput("reset_cnt", conflictCnt, 16'h0000);
        nextCycle();
        reset = 1'b1;

        // Single write from source 0
        nextCycle();
        addrArr[0] = 5'd5; dataArr[0] = 32'hDEADBEEF; reqValid = 3'b001;
        @(negedge clk);
        checkOutput("t1_ready", reqReady, 3'b001);
        nextCycle();
        reqValid = 3'b000;
        @(negedge clk);
        checkOutput("t1_we", rfWe, 1'b1);
        checkOutput("t1_waddr", rfWaddr, 5'd5);
        checkOutput("t1_wdata", rfWdata, 32'hDEADBEEF);
        nextCycle();
        @(negedge clk);
        checkOutput("t1_we_drop", rfWe, 1'b0);

        // Grant source 2 alone so the pointer wraps back to 0
        nextCycle();
        addrArr[2] = 5'd9; dataArr[2] = 32'h0000_0099; reqValid = 3'b100;
        nextCycle();
        addrArr[0] = 5'd1; dataArr[0] = 32'hA0A0_0000;
        addrArr[1] = 5'd2; dataArr[1] = 32'hA1A1_0001;
        addrArr[2] = 5'd3; dataArr[2] = 32'hA2A2_0002;
        reqValid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("t2_rr_grant", reqReady, expSeq[i]);
            nextCycle();
        end

        // Address-0 write right after a real write: accepted, discarded
        addrArr[1] = 5'd0; dataArr[1] = 32'hBAD0_BAD0; reqValid = 3'b010;
        @(negedge clk);
        checkOutput("t2_cnt", conflictCnt, 16'd6);
        checkOutput("t3_ready", reqReady, 3'b010);
        checkOutput("t3_prev_we", rfWe, 1'b1);
        nextCycle();
        reqValid = 3'b101;
        @(negedge clk);
        checkOutput("t3_we", rfWe, 1'b0);
        checkOutput("t3_ptr2", reqReady, 3'b100);

        // Bypass hit on a write in flight
        nextCycle();
        addrArr[0] = 5'd7; dataArr[0] = 32'h12345678; reqValid = 3'b001;
        qAddr1 = 5'd7; qAddr2 = 5'd0;
        nextCycle();
        reqValid = 3'b000;
        @(negedge clk);
        checkOutput("t4_hit1", fwdHit1, 1'b1);
        checkOutput("t4_hit2", fwdHit2, 1'b0);
        checkOutput("t4_fwd", fwdData, 32'h12345678);
        checkOutput("t4_cnt", conflictCnt, 16'd7);

        // Reset on the edge after an accept
        nextCycle();
        addrArr[1] = 5'd4; dataArr[1] = 32'h55AA_55AA; reqValid = 3'b011;
        @(negedge clk);
        checkOutput("t5_ready", reqReady, 3'b010);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_ready_rst", reqReady, 3'b000);
        checkOutput("t5_we_inflight", rfWe, 1'b1);
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_we", rfWe, 1'b0);
        checkOutput("t5_waddr", rfWaddr, 5'd0);
        checkOutput("t5_cnt", conflictCnt, 16'd0);
        checkOutput("t5_ptr0", reqReady, 3'b001);

        // Saturation of the conflict counter
        repeat (65540) nextCycle();
        @(negedge clk);
        checkOutput("t6_sat", conflictCnt, 16'hFFFF);
        nextCycle();
        @(negedge clk);
        checkOutput("t6_sat_hold", conflictCnt, 16'hFFFF);
        reqValid = 3'b000;
        nextCycle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
